timer_irq_ctrl: RTL
===================

Name: timer_irq_ctrl

Overview:
- APB slave that aggregates the per-timer overflow/compare interrupt lines of the timer subsystem into one CPU interrupt.
- Detects rising edges into per-source pending bits and masks them with a per-source enable.
- Picks one source round-robin and sequences a claim/complete handshake so only one timer interrupt is in service at a time.
- Sits between the timer block's irq vector and the core's interrupt input, on the same APB bus segment.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width (4KB slave window).
- NUM_SRC, 4, number of interrupt sources (2 per timer; 2..32).
- ID_W, $clog2(NUM_SRC), source id width. Derived; do not override.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset. Synchronous, active-low.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB write strobe.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready. Constant 1.
- PSLVERR  out  1  APB error.
- irq_src_i  in  NUM_SRC  timer interrupt lines, bit i = source i.
- irq_o  out  1  registered interrupt request to core.
- irq_id_o  out  ID_W  registered id of current arbitration winner.

Behaviour:
- Reset (HRESETn low at a HCLK edge):
  - PENDING, ENABLE, src_q, rr_ptr, in-service id: 0.
  - State: IDLE. irq_o=0, irq_id_o=0.
  - PRDATA=0, PSLVERR=0.
  - Reset mid-transaction discards the access and any pending state.
- Edge detect:
  - src_q registers irq_src_i.
  - PENDING[i] sets at the edge where irq_src_i[i]=1 and src_q[i]=0.
  - A held-high level sets PENDING once only.
  - Disabled sources still accumulate PENDING.
- APB access: zero wait states. Writes and claim side effects act on PSEL & PENABLE.
- Register map (PADDR[4:2]):
  - 0x00 PENDING: RO.
  - 0x04 ENABLE: RW, bits [NUM_SRC-1:0].
  - 0x08 CLEAR: WO, write-1-to-clear PENDING.
  - 0x0C CLAIM: RO with side effect.
  - 0x10 COMPLETE: WO, PWDATA[ID_W-1:0] = id.
  - 0x14 STATUS: RO, bit31 = state==SERVICE, [ID_W-1:0] = in-service id.
- Other offsets: PRDATA=0, PSLVERR=1 (access phase only); writes ignored. Reads of WO registers return 0.
- Eligible set: PENDING & ENABLE.
- Winner: first eligible index searching upward from rr_ptr+1, modulo NUM_SRC.
- FSM:
  - IDLE -> SERVICE on a CLAIM read when the eligible set is non-empty.
    - PRDATA = {1'b1, zeros, winner}.
    - PENDING[winner] clears.
    - In-service id <= winner; rr_ptr <= winner.
  - CLAIM read with an empty eligible set, or while in SERVICE: PRDATA=0, no state change.
  - SERVICE -> IDLE on a COMPLETE write whose id equals the in-service id. A mismatching id is ignored with PSLVERR=0.
- irq_o: registered; 1 iff state==IDLE and eligible set non-empty. Low in SERVICE (no nesting).
- irq_id_o: registered winner each cycle; 0 when none.
- Latency:
  - irq_src_i rise sampled at edge k -> PENDING at k -> irq_o at k+1.
  - Claim at edge k -> irq_o low after k+1.
- Simultaneous events:
  - New edge on source i in the same cycle as CLEAR or claim of i: set wins, PENDING[i] stays 1.
  - ENABLE write takes effect on eligibility the following cycle.
  - PENDING bits for indices >= NUM_SRC read 0.

Decomposition:
- Package timer_irq_pkg holds:
  - Register offset localparams (PENDING, ENABLE, CLEAR, CLAIM, COMPLETE, STATUS).
  - FSM enum state_t {IDLE, SERVICE}.
  - CLAIM_VALID_BIT = 31.
- Sub-module rr_arbiter: combinational round-robin picker.
  - Parameter N.
  - Inputs: req[N], ptr.
  - Outputs: gnt_valid, gnt_id.
  - Shared with future APB peripheral arbiters.

Test Plan:
- Reset, then ENABLE=0xF, pulse irq_src_i[2] for 1 cycle -> PENDING=0x4 next edge, irq_o=1 one cycle later, irq_id_o=2; CLAIM read returns 0x80000002, irq_o=0; COMPLETE write 2 -> IDLE, irq_o stays 0.
- ENABLE=0xF, sources 0,1,3 pending, rr_ptr=0 -> successive claim/complete pairs return ids 1, 3, 0 in that order.
- ENABLE=0x1, source 3 edge -> PENDING=0x8, irq_o=0; write ENABLE=0x9 -> irq_o=1 next cycle, id 3.
- In SERVICE (id 1), write COMPLETE=2 -> STATUS stays 0x80000001; second CLAIM returns 0; COMPLETE=1 -> STATUS=0.
- Source 0 edge coincident with CLEAR write 0x1 -> PENDING[0]=1. irq_src_i[0] held high 10 cycles -> exactly one claim succeeds.
- Read offset 0x18 -> PSLVERR=1, PRDATA=0. Assert HRESETn=0 while in SERVICE with PENDING=0x6 -> all state 0, irq_o=0 after the edge.

Source files
------------

// File: rtl/timer_irq_ctrl_pkg.sv
// Shared definitions for the timer interrupt controller: register offsets,
// controller state encoding and the claim-word layout.
package timer_irq_pkg;

  localparam logic [4:0] REG_PENDING  = 5'h00;
  localparam logic [4:0] REG_ENABLE   = 5'h04;
  localparam logic [4:0] REG_CLEAR    = 5'h08;
  localparam logic [4:0] REG_CLAIM    = 5'h0C;
  localparam logic [4:0] REG_COMPLETE = 5'h10;
  localparam logic [4:0] REG_STATUS   = 5'h14;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  localparam int CLAIM_VALID_BIT = 31;

endpackage

// File: rtl/timer_irq_ctrl_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester found searching
// upward from ptr+1, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_id
);

  logic [W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int off = N; off >= 1; off--) begin
      idx = W'((int'(ptr) + off) % N);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// APB interrupt aggregator for the timer block: edge-detected pending bits,
// per-source enables, round-robin winner and a claim/complete service handshake.
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_SRC        = 4,
  parameter int ID_W           = $clog2(NUM_SRC)
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_SRC-1:0]        irq_src_i,
  output logic                      irq_o,
  output logic [ID_W-1:0]           irq_id_o
);

  logic               access, rd_en, wr_en, hi_zero, addr_ok;
  logic               sel_pending, sel_enable, sel_clear, sel_claim, sel_complete, sel_status;
  logic [NUM_SRC-1:0] src_q, pending_reg, pending_next, enable_reg, eligible;
  logic [NUM_SRC-1:0] rise, clear_mask, claim_mask;
  state_t             state_reg, state_next;
  logic [ID_W-1:0]    inserv_reg, rr_ptr_reg, irq_id_reg;
  logic               irq_reg;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               claim_fire, complete_fire;
  logic [31:0]        rdata;
  logic               unused_wdata;

  assign access  = PSEL && PENABLE;
  assign rd_en   = access && !PWRITE;
  assign wr_en   = access && PWRITE;
  assign hi_zero = (PADDR[APB_ADDR_WIDTH-1:5] == '0);

  assign sel_pending  = hi_zero && (PADDR[4:0] == REG_PENDING);
  assign sel_enable   = hi_zero && (PADDR[4:0] == REG_ENABLE);
  assign sel_clear    = hi_zero && (PADDR[4:0] == REG_CLEAR);
  assign sel_claim    = hi_zero && (PADDR[4:0] == REG_CLAIM);
  assign sel_complete = hi_zero && (PADDR[4:0] == REG_COMPLETE);
  assign sel_status   = hi_zero && (PADDR[4:0] == REG_STATUS);
  assign addr_ok      = sel_pending | sel_enable | sel_clear | sel_claim | sel_complete | sel_status;

  // Upper write-data bits have no register behind them.
  assign unused_wdata = &{1'b0, PWDATA};

  assign eligible      = pending_reg & enable_reg;
  assign rise          = irq_src_i & ~src_q;
  assign clear_mask    = (wr_en && sel_clear) ? PWDATA[NUM_SRC-1:0] : '0;
  assign claim_fire    = rd_en && sel_claim && (state_reg == IDLE) && gnt_valid;
  assign complete_fire = wr_en && sel_complete && (state_reg == SERVICE) &&
                         (PWDATA[ID_W-1:0] == inserv_reg);

  rr_arbiter #(
    .N (NUM_SRC),
    .W (ID_W)
  ) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr_reg),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // A fresh rising edge always beats a clear or claim in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
      assign claim_mask[gi]   = claim_fire && (gnt_id == ID_W'(gi));
      assign pending_next[gi] = rise[gi] |
                                (pending_reg[gi] & ~clear_mask[gi] & ~claim_mask[gi]);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (claim_fire)    state_next = SERVICE;
      SERVICE: if (complete_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      src_q       <= '0;
      pending_reg <= '0;
      enable_reg  <= '0;
      inserv_reg  <= '0;
      rr_ptr_reg  <= '0;
      irq_reg     <= 1'b0;
      irq_id_reg  <= '0;
    end else begin
      src_q       <= irq_src_i;
      pending_reg <= pending_next;
      if (wr_en && sel_enable) enable_reg <= PWDATA[NUM_SRC-1:0];
      if (claim_fire) begin
        inserv_reg <= gnt_id;
        rr_ptr_reg <= gnt_id;
      end else if (complete_fire) begin
        inserv_reg <= '0;
      end
      irq_reg    <= (state_reg == IDLE) && gnt_valid;
      irq_id_reg <= gnt_valid ? gnt_id : '0;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_pending) rdata = 32'(pending_reg);
    if (sel_enable)  rdata = 32'(enable_reg);
    if (sel_claim && (state_reg == IDLE) && gnt_valid) begin
      rdata                  = 32'(gnt_id);
      rdata[CLAIM_VALID_BIT] = 1'b1;
    end
    if (sel_status) begin
      rdata[31]       = (state_reg == SERVICE);
      rdata[ID_W-1:0] = inserv_reg;
    end
  end

  assign PRDATA   = rd_en ? rdata : '0;
  assign PSLVERR  = access && !addr_ok;
  assign PREADY   = 1'b1;
  assign irq_o    = irq_reg;
  assign irq_id_o = irq_id_reg;

endmodule
